// File: rtl/uart_rx_frame_ctrl.sv
// UART byte-stream to SOF/CMD/ARG/CHK frame parser with checksum,
// inter-byte timeout and a single-entry acknowledged command register.
module uart_rx_frame_ctrl #(
  parameter logic [7:0] SOF_BYTE     = 8'hAA,
  parameter int         TIMEOUT_CLKS = 50000
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  input  logic       i_Cmd_Ack,
  output logic       o_Cmd_Valid,
  output logic [7:0] o_Cmd,
  output logic [7:0] o_Arg,
  output logic       o_Err,
  output logic [1:0] o_Err_Code,
  output logic       o_Busy,
  output logic [7:0] o_Frame_Count
);

  localparam int TW = $clog2(TIMEOUT_CLKS);
  localparam logic [TW-1:0] T_FIRE = TW'(TIMEOUT_CLKS - 2);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CLKS - 1);

  localparam logic [1:0] E_CHK  = 2'b01;
  localparam logic [1:0] E_TOUT = 2'b10;
  localparam logic [1:0] E_OVR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_ARG,
    S_CHK
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [7:0]    cmd_tmp;
  logic [7:0]    arg_tmp;
  logic          good_chk;
  logic          ack_now;

  assign o_Busy   = (state != S_IDLE);
  assign good_chk = (i_Rx_Byte == (cmd_tmp ^ arg_tmp));
  assign ack_now  = i_Cmd_Ack && o_Cmd_Valid;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state         <= S_IDLE;
      timer         <= '0;
      cmd_tmp       <= '0;
      arg_tmp       <= '0;
      o_Cmd_Valid   <= 1'b0;
      o_Cmd         <= '0;
      o_Arg         <= '0;
      o_Err         <= 1'b0;
      o_Err_Code    <= 2'b00;
      o_Frame_Count <= '0;
    end else begin
      o_Err <= 1'b0;
      if (ack_now)
        o_Cmd_Valid <= 1'b0;

      if (i_Rx_DV) begin
        timer <= '0;
        unique case (state)
          S_IDLE: begin
            if (i_Rx_Byte == SOF_BYTE)
              state <= S_CMD;
          end
          S_CMD: begin
            cmd_tmp <= i_Rx_Byte;
            state   <= S_ARG;
          end
          S_ARG: begin
            arg_tmp <= i_Rx_Byte;
            state   <= S_CHK;
          end
          S_CHK: begin
            state <= S_IDLE;
            if (!good_chk) begin
              o_Err      <= 1'b1;
              o_Err_Code <= E_CHK;
            end else if (o_Cmd_Valid && !i_Cmd_Ack) begin
              // Pending command wins; the new frame is dropped.
              o_Err      <= 1'b1;
              o_Err_Code <= E_OVR;
            end else begin
              o_Cmd_Valid   <= 1'b1;
              o_Cmd         <= cmd_tmp;
              o_Arg         <= arg_tmp;
              o_Frame_Count <= o_Frame_Count + 8'd1;
            end
          end
        endcase
      end else if (state != S_IDLE) begin
        // Fires on the edge where the timer would reach TIMEOUT_CLKS-1.
        if (timer == T_FIRE) begin
          state      <= S_IDLE;
          timer      <= '0;
          o_Err      <= 1'b1;
          o_Err_Code <= E_TOUT;
        end else if (timer != T_MAX) begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: framing, checksum, timeout,
// overrun, resync, async reset and frame counter wrap.
module tb_uart_rx_frame_ctrl;

  logic       clk;
  logic       rst;
  logic       dv;
  logic [7:0] rx_byte;
  logic       ack;
  logic       cmd_valid;
  logic [7:0] cmd;
  logic [7:0] arg;
  logic       err;
  logic [1:0] err_code;
  logic       busy;
  logic [7:0] frame_count;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_frame_ctrl #(
    .SOF_BYTE    (8'hAA),
    .TIMEOUT_CLKS(100)
  ) dut (
    .i_Clock      (clk),
    .i_Reset      (rst),
    .i_Rx_DV      (dv),
    .i_Rx_Byte    (rx_byte),
    .i_Cmd_Ack    (ack),
    .o_Cmd_Valid  (cmd_valid),
    .o_Cmd        (cmd),
    .o_Arg        (arg),
    .o_Err        (err),
    .o_Err_Code   (err_code),
    .o_Busy       (busy),
    .o_Frame_Count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send(input logic [7:0] b);
    dv      = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1;
    dv      = 1'b0;
    rx_byte = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_reset();
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", cmd_valid); end
    n_checks++; if (cmd !== 8'h00) begin n_fail++; $display("FAIL rst_cmd: got %h want 00", cmd); end
    n_checks++; if (arg !== 8'h00) begin n_fail++; $display("FAIL rst_arg: got %h want 00", arg); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
    n_checks++; if (err_code !== 2'b00) begin n_fail++; $display("FAIL rst_code: got %b want 00", err_code); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (frame_count !== 8'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", frame_count); end
  endtask

  task automatic test_good_frame();
    do_reset();
    send(8'hAA);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL good_busy: got %b want 1", busy); end
    send(8'h12); send(8'h34); send(8'h26);
    n_checks++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL good_valid: got %b want 1", cmd_valid); end
    n_checks++; if (cmd !== 8'h12) begin n_fail++; $display("FAIL good_cmd: got %h want 12", cmd); end
    n_checks++; if (arg !== 8'h34) begin n_fail++; $display("FAIL good_arg: got %h want 34", arg); end
    n_checks++; if (frame_count !== 8'd1) begin n_fail++; $display("FAIL good_count: got %0d want 1", frame_count); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL good_err: got %b want 0", err); end
    idle(3);
    n_checks++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL good_hold: got %b want 1", cmd_valid); end
    do_ack();
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL good_ack: got %b want 0", cmd_valid); end
    do_ack();
    n_checks++; if (frame_count !== 8'd1) begin n_fail++; $display("FAIL good_stray_ack: got %0d want 1", frame_count); end
  endtask

  task automatic test_bad_checksum();
    do_reset();
    send(8'hAA); send(8'h12); send(8'h34); send(8'h27);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL chk_err: got %b want 1", err); end
    n_checks++; if (err_code !== 2'b01) begin n_fail++; $display("FAIL chk_code: got %b want 01", err_code); end
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL chk_valid: got %b want 0", cmd_valid); end
    n_checks++; if (frame_count !== 8'd0) begin n_fail++; $display("FAIL chk_count: got %0d want 0", frame_count); end
    idle(1);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL chk_pulse: got %b want 0", err); end
    n_checks++; if (err_code !== 2'b01) begin n_fail++; $display("FAIL chk_code_hold: got %b want 01", err_code); end
    send(8'hAA); send(8'h01); send(8'h02); send(8'h03);
    n_checks++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL chk_next_valid: got %b want 1", cmd_valid); end
    n_checks++; if (cmd !== 8'h01) begin n_fail++; $display("FAIL chk_next_cmd: got %h want 01", cmd); end
    n_checks++; if (arg !== 8'h02) begin n_fail++; $display("FAIL chk_next_arg: got %h want 02", arg); end
    n_checks++; if (frame_count !== 8'd1) begin n_fail++; $display("FAIL chk_next_count: got %0d want 1", frame_count); end
  endtask

  task automatic test_timeout();
    do_reset();
    send(8'hAA); send(8'h12);
    idle(98);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b want 0", err); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL to_busy_pre: got %b want 1", busy); end
    idle(1);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b want 1", err); end
    n_checks++; if (err_code !== 2'b10) begin n_fail++; $display("FAIL to_code: got %b want 10", err_code); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to_busy: got %b want 0", busy); end
    idle(1);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL to_pulse: got %b want 0", err); end
    send(8'hAA); send(8'h12);
    idle(98);
    send(8'h34);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL to_race_err: got %b want 0", err); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL to_race_busy: got %b want 1", busy); end
    send(8'h26);
    n_checks++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL to_race_valid: got %b want 1", cmd_valid); end
    n_checks++; if (cmd !== 8'h12) begin n_fail++; $display("FAIL to_race_cmd: got %h want 12", cmd); end
    n_checks++; if (arg !== 8'h34) begin n_fail++; $display("FAIL to_race_arg: got %h want 34", arg); end
  endtask

  task automatic test_overrun();
    do_reset();
    send(8'hAA); send(8'h01); send(8'h02); send(8'h03);
    send(8'hAA); send(8'h05); send(8'h06); send(8'h03);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL ovr_err: got %b want 1", err); end
    n_checks++; if (err_code !== 2'b11) begin n_fail++; $display("FAIL ovr_code: got %b want 11", err_code); end
    n_checks++; if (cmd !== 8'h01) begin n_fail++; $display("FAIL ovr_cmd: got %h want 01", cmd); end
    n_checks++; if (arg !== 8'h02) begin n_fail++; $display("FAIL ovr_arg: got %h want 02", arg); end
    n_checks++; if (frame_count !== 8'd1) begin n_fail++; $display("FAIL ovr_count: got %0d want 1", frame_count); end
    n_checks++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b want 1", cmd_valid); end
    send(8'hAA); send(8'h05); send(8'h06);
    ack = 1'b1;
    send(8'h03);
    ack = 1'b0;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ovr_ack_err: got %b want 0", err); end
    n_checks++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_ack_valid: got %b want 1", cmd_valid); end
    n_checks++; if (cmd !== 8'h05) begin n_fail++; $display("FAIL ovr_ack_cmd: got %h want 05", cmd); end
    n_checks++; if (arg !== 8'h06) begin n_fail++; $display("FAIL ovr_ack_arg: got %h want 06", arg); end
    n_checks++; if (frame_count !== 8'd2) begin n_fail++; $display("FAIL ovr_ack_count: got %0d want 2", frame_count); end
  endtask

  task automatic test_resync();
    do_reset();
    send(8'h55);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rs_noise_busy: got %b want 0", busy); end
    send(8'hAA); send(8'hAA); send(8'hAA); send(8'h00);
    n_checks++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL rs_valid: got %b want 1", cmd_valid); end
    n_checks++; if (cmd !== 8'hAA) begin n_fail++; $display("FAIL rs_cmd: got %h want AA", cmd); end
    n_checks++; if (arg !== 8'hAA) begin n_fail++; $display("FAIL rs_arg: got %h want AA", arg); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rs_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    send(8'hAA); send(8'h12); send(8'h34); send(8'h26);
    send(8'hAA); send(8'h12);
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", cmd_valid); end
    n_checks++; if (cmd !== 8'h00) begin n_fail++; $display("FAIL mid_cmd: got %h want 00", cmd); end
    n_checks++; if (frame_count !== 8'd0) begin n_fail++; $display("FAIL mid_count: got %0d want 0", frame_count); end
    #2;
    rst = 1'b0;
    idle(1);
    send(8'h34); send(8'h26);
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale_valid: got %b want 0", cmd_valid); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL mid_stale_err: got %b want 0", err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_stale_busy: got %b want 0", busy); end
    send(8'hAA); send(8'h12); send(8'h34); send(8'h26);
    n_checks++; if (cmd !== 8'h12) begin n_fail++; $display("FAIL mid_fresh_cmd: got %h want 12", cmd); end
    n_checks++; if (frame_count !== 8'd1) begin n_fail++; $display("FAIL mid_fresh_count: got %0d want 1", frame_count); end
  endtask

  task automatic test_count_wrap();
    logic [7:0] exp_cnt;
    logic [7:0] c;
    logic [7:0] a;
    do_reset();
    exp_cnt = 8'd0;
    for (int i = 0; i < 256; i++) begin
      c = 8'(i);
      a = 8'(i * 3 + 1);
      send(8'hAA); send(c); send(a); send(c ^ a);
      exp_cnt = exp_cnt + 8'd1;
      n_checks++; if (frame_count !== exp_cnt || cmd !== c) begin n_fail++; $display("FAIL wrap_%0d: got cnt %0d cmd %h want cnt %0d cmd %h", i, frame_count, cmd, exp_cnt, c); end
      do_ack();
    end
    n_checks++; if (frame_count !== 8'd0) begin n_fail++; $display("FAIL wrap_zero: got %0d want 0", frame_count); end
  endtask

  initial begin
    rst     = 1'b1;
    dv      = 1'b0;
    rx_byte = 8'h00;
    ack     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    idle(1);
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_timeout();
    test_overrun();
    test_resync();
    test_reset_mid_frame();
    test_count_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Sequences the byte stream from the UART receiver (i_Rx_DV / i_Rx_Byte, one-cycle DV pulse per received byte) into 4-byte command frames: SOF, CMD, ARG, CHK.
It validates the checksum, enforces an inter-byte timeout and holds each decoded command in an output register until the consumer acknowledges it.
It sits between uart_rx and the command/sensor-control logic.

Parameters:
SOF_BYTE, 8'hAA, start-of-frame marker.
TIMEOUT_CLKS, 50000, maximum clocks allowed between consecutive bytes of one frame (must be ≥2).

Ports:
i_Clock  in  1  system clock, all logic on the rising edge.
i_Reset  in  1  asynchronous, active-high reset.
i_Rx_DV  in  1  one-cycle pulse: i_Rx_Byte is valid.
i_Rx_Byte  in  8  received byte.
i_Cmd_Ack  in  1  consumer has taken o_Cmd/o_Arg.
o_Cmd_Valid  out  1  a decoded command is pending; held until acknowledged.
o_Cmd  out  8  command byte of the pending frame.
o_Arg  out  8  argument byte of the pending frame.
o_Err  out  1  one-cycle error pulse.
o_Err_Code  out  2  01 = checksum, 10 = timeout, 11 = overrun; held until the next error.
o_Busy  out  1  high while the parser is in any state other than S_IDLE.
o_Frame_Count  out  8  count of good frames delivered; wraps 255→0.

Behaviour:
- Reset: the clock and reset are fixed as one clock, with reset asynchronous and active-high.
  - Reset forces: parser to S_IDLE, timer = 0, o_Cmd_Valid = 0, o_Cmd = 0, o_Arg = 0, o_Err = 0, o_Err_Code = 00, o_Busy = 0, o_Frame_Count = 0.
  - Reset mid-frame discards the partial frame; no error is reported.
- Parser FSM (advances only on the i_Rx_DV cycle unless the timeout fires):
  - S_IDLE: a byte equal to SOF_BYTE → S_CMD. Any other byte is ignored.
  - S_CMD: store the byte as cmd_tmp → S_ARG.
  - S_ARG: store the byte as arg_tmp → S_CHK.
  - S_CHK: if byte == cmd_tmp ^ arg_tmp, the frame is good → S_IDLE. Otherwise pulse o_Err with code 01 → S_IDLE.
  - SOF_BYTE seen inside S_CMD/S_ARG/S_CHK is plain data; it does not resync the parser.
- Timeout:
  - The timer clears on entry to S_CMD and on every accepted byte, and increments each clock while in S_CMD, S_ARG or S_CHK.
  - When the timer reaches TIMEOUT_CLKS-1 with no DV: pulse o_Err with code 10 → S_IDLE.
  - If a DV pulse arrives on the same cycle as expiry, the byte wins: it is processed normally and there is no timeout.
  - Timer width is $clog2(TIMEOUT_CLKS); it saturates and never wraps.
- Output register and handshake:
  - A good frame completes on the DV cycle of the CHK byte. On the next cycle o_Cmd_Valid = 1, o_Cmd = cmd_tmp, o_Arg = arg_tmp, and o_Frame_Count increments (latency 1 clock).
  - o_Cmd, o_Arg and o_Cmd_Valid stay stable until the first clock with i_Cmd_Ack = 1 while o_Cmd_Valid = 1; o_Cmd_Valid is low on the following cycle.
  - i_Cmd_Ack while o_Cmd_Valid = 0 is ignored.
  - The parser keeps receiving while a command is pending.
  - If a good frame completes while o_Cmd_Valid = 1 and i_Cmd_Ack = 0, the new frame is dropped. Result: o_Err pulses with code 11, the old command stays pending, and o_Frame_Count is unchanged.
  - If i_Cmd_Ack = 1 on the same cycle a good frame completes, the old command is consumed and the new one is loaded. o_Cmd_Valid stays 1, there is no overrun, and the count increments.
- Errors:
  - o_Err is high for exactly one clock per event.
  - Checksum and overrun can only occur on a CHK byte cycle, and timeout only when no DV is present, so at most one error fires per cycle.
- o_Busy: combinational, equal to (state != S_IDLE).

Test Plan:
1. Good frame: send AA 12 34 26 with i_Cmd_Ack = 0 → one cycle after the CHK DV, o_Cmd_Valid = 1, o_Cmd = 12, o_Arg = 34, o_Frame_Count = 1. Assert i_Cmd_Ack for one cycle → o_Cmd_Valid = 0 on the next cycle.
2. Bad checksum: send AA 12 34 27 → o_Err pulses once with o_Err_Code = 01; o_Cmd_Valid stays 0 and o_Frame_Count stays 0. A following AA 01 02 03 is accepted normally.
3. Timeout: set TIMEOUT_CLKS = 100 and send AA 12, then silence → o_Err with code 10 exactly 99 clocks after the 12 DV, and o_Busy falls. Repeat with the next DV landing on the expiry cycle → no error and the frame continues.
4. Overrun: send AA 01 02 03, then AA 05 06 03, never acking → the second frame gives o_Err with code 11; o_Cmd/o_Arg remain 01/02 and the count remains 1. Repeat with the ack coinciding with the second CHK DV → o_Cmd = 05, o_Arg = 06, count = 2, no error.
5. Resync and noise: send 55 AA AA AA 00 → no SOF resync (CMD = AA, ARG = AA), CHK 00 = AA^AA is good → o_Cmd = AA, o_Arg = AA.
6. Reset mid-frame: send AA 12 and pulse i_Reset asynchronously (between clock edges) → all outputs 0 immediately, o_Busy = 0. Then 34 26 arriving afterwards are ignored, and a fresh frame decodes correctly. Also cover 256 good acked frames → o_Frame_Count wraps to 0.
